// File: rtl/ripple_count_capture_if.sv
// Bus between the ripple-counter capture block and its synchronous consumer.
// The master side drives the raw counter and compare value; the slave side returns the captured view.
interface ripple_count_capture_if #(
  parameter int WIDTH     = 4,
  parameter int EXT_WIDTH = 4
);
  logic [WIDTH-1:0]           count_in;
  logic [WIDTH+EXT_WIDTH-1:0] match_val_in;
  logic                       count_valid_out;
  logic [WIDTH-1:0]           count_out;
  logic [WIDTH+EXT_WIDTH-1:0] ext_count_out;
  logic                       change_pulse_out;
  logic                       wrap_pulse_out;
  logic                       match_pulse_out;
  logic                       overflow_out;

  modport master (
    output count_in,
    output match_val_in,
    input  count_valid_out,
    input  count_out,
    input  ext_count_out,
    input  change_pulse_out,
    input  wrap_pulse_out,
    input  match_pulse_out,
    input  overflow_out
  );

  modport slave (
    input  count_in,
    input  match_val_in,
    output count_valid_out,
    output count_out,
    output ext_count_out,
    output change_pulse_out,
    output wrap_pulse_out,
    output match_pulse_out,
    output overflow_out
  );
endinterface

// File: rtl/ripple_count_capture.sv
// Captures an asynchronous ripple-counter bus into the clk domain, filters ripple transients,
// extends the value with a wrap counter and produces single-cycle change/wrap/match events.
module ripple_count_capture #(
  parameter int WIDTH       = 4,
  parameter int EXT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_in,
  ripple_count_capture_if.slave bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
  logic [SYNC_STAGES:0] fill_r;
  logic [WIDTH-1:0]     cand_r;
  logic [WIDTH-1:0]     sync_q_s;
  logic                 stable_s;

  state_t               state_r;
  state_t               state_nx_s;
  logic [WIDTH-1:0]     count_r;
  logic [WIDTH-1:0]     count_nx_s;
  logic [EXT_WIDTH-1:0] wrap_cnt_r;
  logic [EXT_WIDTH-1:0] wrap_cnt_nx_s;
  logic                 valid_r;
  logic                 valid_nx_s;
  logic                 overflow_r;
  logic                 overflow_nx_s;
  logic                 change_r;
  logic                 change_nx_s;
  logic                 wrap_pulse_r;
  logic                 wrap_pulse_nx_s;
  logic                 match_r;
  logic                 match_nx_s;

  assign sync_q_s = sync_r[SYNC_STAGES-1];
  // fill_r marks which stages hold real samples, so reset-cleared zeros are never taken as stable.
  assign stable_s = fill_r[SYNC_STAGES] && (sync_q_s == cand_r);

  // Synchronizer chain, candidate register and fill tracker.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      fill_r <= {(SYNC_STAGES+1){1'b0}};
      cand_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= bus.count_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      fill_r <= {fill_r[SYNC_STAGES-1:0], 1'b1};
      cand_r <= sync_q_s;
    end
  end

  // Next-state and next-output decode for the capture FSM.
  always_comb begin
    state_nx_s      = state_r;
    count_nx_s      = count_r;
    wrap_cnt_nx_s   = wrap_cnt_r;
    valid_nx_s      = valid_r;
    overflow_nx_s   = overflow_r;
    change_nx_s     = 1'b0;
    wrap_pulse_nx_s = 1'b0;
    match_nx_s      = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (stable_s) begin
          count_nx_s = sync_q_s;
          valid_nx_s = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          valid_nx_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (stable_s && (sync_q_s != count_r)) begin
          count_nx_s  = sync_q_s;
          change_nx_s = 1'b1;
          // Any decrease counts as a wrap, modulo or not.
          if (sync_q_s < count_r) begin
            wrap_pulse_nx_s = 1'b1;
            if (wrap_cnt_r == {EXT_WIDTH{1'b1}}) begin
              wrap_cnt_nx_s = {EXT_WIDTH{1'b0}};
              overflow_nx_s = 1'b1;
            end else begin
              wrap_cnt_nx_s = wrap_cnt_r + {{(EXT_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            wrap_cnt_nx_s = wrap_cnt_r;
          end
          match_nx_s = ({wrap_cnt_nx_s, sync_q_s} == bus.match_val_in);
        end else begin
          change_nx_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = ST_INIT;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_r      <= ST_INIT;
      count_r      <= {WIDTH{1'b0}};
      wrap_cnt_r   <= {EXT_WIDTH{1'b0}};
      valid_r      <= 1'b0;
      overflow_r   <= 1'b0;
      change_r     <= 1'b0;
      wrap_pulse_r <= 1'b0;
      match_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      count_r      <= count_nx_s;
      wrap_cnt_r   <= wrap_cnt_nx_s;
      valid_r      <= valid_nx_s;
      overflow_r   <= overflow_nx_s;
      change_r     <= change_nx_s;
      wrap_pulse_r <= wrap_pulse_nx_s;
      match_r      <= match_nx_s;
    end
  end

  assign bus.count_valid_out  = valid_r;
  assign bus.count_out        = count_r;
  assign bus.ext_count_out    = {wrap_cnt_r, count_r};
  assign bus.change_pulse_out = change_r;
  assign bus.wrap_pulse_out   = wrap_pulse_r;
  assign bus.match_pulse_out  = match_r;
  assign bus.overflow_out     = overflow_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed and randomized bench for ripple_count_capture, checked against a wrap-count model
// plus a behavioural ripple counter with staggered bit delays.
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       slow_clk = 1'b0;
  logic       reset_in;
  logic [3:0] drv;
  logic       use_ripple;
  logic       rc0 = 1'b0;
  logic       rc1 = 1'b0;
  logic       rc2 = 1'b0;
  logic       rc3 = 1'b0;
  logic [3:0] rc_val;

  int checks   = 0;
  int failures = 0;
  int m_cnt    = 0;
  int m_wraps  = 0;

  ripple_count_capture_if #(.WIDTH(4), .EXT_WIDTH(4)) bus ();

  ripple_count_capture #(.WIDTH(4), .EXT_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always #40 slow_clk = ~slow_clk;

  // Ripple counter: each bit toggles 3 time units after the falling edge of the bit below.
  always @(posedge slow_clk) begin #3; rc0 = ~rc0; end
  always @(negedge rc0) begin #3; rc1 = ~rc1; end
  always @(negedge rc1) begin #3; rc2 = ~rc2; end
  always @(negedge rc2) begin #3; rc3 = ~rc3; end
  assign rc_val = {rc3, rc2, rc1, rc0};

  assign bus.count_in = use_ripple ? rc_val : drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input int valid, input int cnt, input int ext,
                           input int chg, input int wr, input int mt, input int ovf);
    chk({tag, ".valid"},  32'(bus.count_valid_out),  32'(valid));
    chk({tag, ".count"},  32'(bus.count_out),        32'(cnt));
    chk({tag, ".ext"},    32'(bus.ext_count_out),    32'(ext));
    chk({tag, ".change"}, 32'(bus.change_pulse_out), 32'(chg));
    chk({tag, ".wrap"},   32'(bus.wrap_pulse_out),   32'(wr));
    chk({tag, ".match"},  32'(bus.match_pulse_out),  32'(mt));
    chk({tag, ".ovf"},    32'(bus.overflow_out),     32'(ovf));
  endtask

  function automatic int model_ext(input int wraps, input int cnt);
    return ((wraps % 16) * 16) + cnt;
  endfunction

  function automatic int next_ext(input int v);
    return model_ext(m_wraps + ((v < m_cnt) ? 1 : 0), v);
  endfunction

  task automatic do_reset(input int v);
    @(negedge clk);
    reset_in = 1'b1;
    drv = 4'(v);
    bus.match_val_in = 8'h23;
    repeat (3) begin
      @(posedge clk); #1;
      check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    reset_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 4) check_all("startup_wait", 0, 0, 0, 0, 0, 0, 0);
      else       check_all("startup_load", 1, v, v, 0, 0, 0, 0);
    end
    m_cnt = v;
    m_wraps = 0;
  endtask

  // Present a new stable value and check latency, pulses and the extended count edge by edge.
  task automatic apply(input int v, input int mval);
    int old_ext, new_ext, new_wraps, chg, wr, mt, old_ovf, new_ovf;
    chg = (v != m_cnt) ? 1 : 0;
    wr = (chg != 0 && v < m_cnt) ? 1 : 0;
    new_wraps = m_wraps + wr;
    old_ext = model_ext(m_wraps, m_cnt);
    new_ext = model_ext(new_wraps, v);
    mt = (chg != 0 && new_ext == (mval & 8'hFF)) ? 1 : 0;
    old_ovf = (m_wraps >= 16) ? 1 : 0;
    new_ovf = (new_wraps >= 16) ? 1 : 0;
    @(negedge clk);
    bus.match_val_in = 8'(mval);
    drv = 4'(v);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 4)       check_all("latency_hold", 1, m_cnt, old_ext, 0, 0, 0, old_ovf);
      else if (k == 4) check_all("update_edge", 1, v, new_ext, chg, wr, mt, new_ovf);
      else             check_all("after_update", 1, v, new_ext, 0, 0, 0, new_ovf);
    end
    m_cnt = v;
    m_wraps = new_wraps;
  endtask

  task automatic glitch(input int g);
    int ext, ovf;
    ext = model_ext(m_wraps, m_cnt);
    ovf = (m_wraps >= 16) ? 1 : 0;
    @(negedge clk); drv = 4'(g);
    @(negedge clk); drv = 4'(m_cnt);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check_all("glitch_reject", 1, m_cnt, ext, 0, 0, 0, ovf);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v, mv;
    reset_in = 1'b1;
    drv = 4'd5;
    use_ripple = 1'b0;
    bus.match_val_in = 8'h23;

    do_reset(5);
    apply(6, 8'h23);
    glitch(7);
    glitch(0);
    apply(3, 8'h23);
    apply(6, 8'h23);
    apply(9, 8'h23);
    apply(2, 8'h23);
    apply(2, 8'h23);

    // Counting from 0: match at 0x23, then overflow after the 16th wrap.
    do_reset(0);
    for (int w = 0; w < 16; w++) begin
      for (int c = 1; c < 16; c++) apply(c, 8'h23);
      apply(0, 8'h23);
    end
    for (int c = 1; c <= 5; c++) apply(c, 8'h23);

    for (int n = 0; n < 30; n++) begin
      v = int'($urandom_range(0, 15));
      if (v > m_cnt && v - m_cnt > 7) v = m_cnt + 7;
      if ($urandom_range(0, 1) == 1) mv = next_ext(v);
      else mv = int'($urandom_range(0, 255));
      apply(v, mv);
    end

    // Ripple counter drives the bus; reset mid-count, then tracking must resume.
    @(negedge clk);
    use_ripple = 1'b1;
    repeat (3) @(posedge slow_clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_in = 1'b1;
    @(posedge clk); #1;
    check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_in = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(posedge slow_clk);
      repeat (6) @(posedge clk);
      #1;
      chk("ripple_track.count", 32'(bus.count_out), 32'(rc_val));
      chk("ripple_track.valid", 32'(bus.count_valid_out), 32'd1);
      chk("ripple_track.ovf", 32'(bus.overflow_out), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
Downstream consumer of the 4-bit asynchronous ripple counter. Brings the counter's count_out bus into the system clk domain through a synchronizer. Accepts a value only after it has been stable for two consecutive synchronized samples, which rejects ripple transients. It then extends the count with a wrap counter and emits single-cycle change, wrap and match events for synchronous logic.

Parameters:
WIDTH, 4, width of the ripple counter bus being captured
EXT_WIDTH, 4, width of the wrap (upper) counter appended above the captured value
SYNC_STAGES, 2, number of synchronizer flops, legal range 2..4

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
count_in  input  WIDTH  ripple counter output, asynchronous to clk
match_val_in  input  WIDTH+EXT_WIDTH  compare value for match_pulse_out; quasi-static
count_valid_out  output  1  high once a first stable value has been accepted
count_out  output  WIDTH  last accepted stable value
ext_count_out  output  WIDTH+EXT_WIDTH  {wrap counter, count_out}
change_pulse_out  output  1  one-cycle pulse when count_out updates
wrap_pulse_out  output  1  one-cycle pulse when an accepted update wraps
match_pulse_out  output  1  one-cycle pulse when ext_count_out takes a value equal to match_val_in
overflow_out  output  1  sticky flag; set when the wrap counter rolls over

Behaviour:
- Reset: reset_in is sampled on the clk rising edge and overrides all other activity. It clears the synchronizer flops, the candidate register, count_out, the wrap counter, all pulses, count_valid_out and overflow_out, and sets the FSM to INIT. Reset asserted mid-operation behaves identically; no partial state survives.
- Synchronizer: count_in passes through SYNC_STAGES flops to give sync_q. The candidate register cand_q holds the previous sync_q. The value is stable when sync_q == cand_q, compared over all bits.
- FSM states: INIT and RUN.
  - INIT: count_valid_out=0 and no pulses. On the first cycle where the value is stable: load count_out from sync_q, keep the wrap counter at 0, set count_valid_out=1, move to RUN. This first load produces no change, wrap or match pulse.
  - RUN: if the value is stable and sync_q != count_out, count_out takes sync_q at the next edge and change_pulse_out=1 for exactly that cycle. Otherwise all pulses are 0.
- Wrap rule: an accepted update with sync_q < count_out (unsigned) is a wrap.
  - The wrap counter increments and wrap_pulse_out=1 in the same cycle as change_pulse_out.
  - If the wrap counter is at all-ones, it goes to 0 and overflow_out sets. overflow_out stays set until reset.
- Match: match_pulse_out=1 in the cycle where the updated ext_count_out equals match_val_in. It is evaluated only on accepted updates, never in INIT or on a hold.
- Latency: count_in changes and stays stable. count_out and the pulses update on rising edge SYNC_STAGES+2 after the change (edge 4 by default). change_pulse_out, wrap_pulse_out, match_pulse_out and the new ext_count_out all appear in the same cycle.
- Transient rejection: a value present on sync_q for a single cycle never reaches count_out.
- Rate limit (usage constraint, not checked): count_in may change at most once per SYNC_STAGES+2 clk cycles. Forward jumps between accepts must be less than 2^(WIDTH-1); otherwise wrap detection is ambiguous.
- Skipped values: a jump of more than 1, e.g. 3 to 6, is accepted as a single update with one change_pulse_out.
- Decreasing jumps: any decrease, including a non-modulo decrease such as 9 to 2, counts as a wrap.
- No changes: with count_in constant, the outputs hold indefinitely and no pulses are generated.

Test Plan:
- Reset then startup: reset_in=1 for 3 cycles, count_in=5, release reset -> count_valid_out=0 until edge 4 after release, then count_out=5, ext_count_out=0x05, no pulses.
- Increment with latency: from count_out=5, set count_in=6 between edges -> count_out=6 and change_pulse_out=1 exactly on edge 4 after the change; pulse width is 1 cycle.
- Glitch rejection: count_in=7 for 1 clk then back to 6 -> count_out stays 6, no pulses. Repeat with a glitch to 0 -> no wrap_pulse_out.
- Wrap and overflow: step count_in through 0..15 and back to 0 repeatedly, 6 cycles per value -> each 15 to 0 gives wrap_pulse_out=1 and upper nibble +1. After the 16th wrap: ext_count_out=0x00, overflow_out=1, which stays 1 through further counting.
- Match: match_val_in=0x23, count from 0 through 2 wraps to 3 -> match_pulse_out=1 only in the cycle ext_count_out becomes 0x23, coincident with change_pulse_out.
- Mid-operation reset and ripple-counter integration: drive count_in from an instance of the ripple counter, sourced from a clock 8x slower than clk. Assert reset_in mid-count -> next cycle all outputs 0, FSM in INIT, overflow_out=0. Tracking then resumes matching the counter value within 4 clk cycles of each change.
